// File: rtl/ccff_chain_loader.sv
// Configuration-chain writer: serialises host words onto the ccff chain head.
// Optional tail readback CRC-8 enabled by defining CCFF_CRC_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 17,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [7:0]        crc_out
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SUB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q;
  logic [SUB_W-1:0]  sub_q;
  logic [SUB_W-1:0]  sub_init;
  logic [WORD_W-1:0] sreg_q;
  logic              head_q;
  logic              en_q;
  logic              take;
  logic              word_end;
  logic              last_bit;

  assign take     = word_valid & word_ready;
  assign word_end = (sub_q == SUB_W'(1));
  assign last_bit = (rem_q == CNT_W'(1));

  // Bits taken from the next word: a full word, or what is left of the chain
  always_comb begin
    sub_init = SUB_W'(WORD_W);
    if (32'(rem_q) < 32'(WORD_W))
      sub_init = SUB_W'(rem_q);
  end

  // State register
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake ready
  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        word_ready = ~abort;
        if (abort)           state_d = IDLE;
        else if (word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)         state_d = IDLE;
        else if (word_end) state_d = last_bit ? FINISH : FETCH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Head bit and shift enable are launched together so each appears
  // for exactly the cycles the loader spends in SHIFT
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      sub_q  <= '0;
      sreg_q <= '0;
      head_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      head_q <= 1'b0;
      en_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) rem_q <= CNT_W'(CHAIN_LEN);
        end
        FETCH: begin
          if (take) begin
            sreg_q <= word_in << 1;
            head_q <= word_in[WORD_W-1];
            en_q   <= 1'b1;
            sub_q  <= sub_init;
          end
        end
        SHIFT: begin
          if (!abort) begin
            rem_q <= rem_q - CNT_W'(1);
            sub_q <= sub_q - SUB_W'(1);
            if (!word_end) begin
              head_q <= sreg_q[WORD_W-1];
              sreg_q <= sreg_q << 1;
              en_q   <= 1'b1;
            end
          end
        end
        FINISH: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = en_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);

`ifdef CCFF_CRC_EN
  logic [7:0] crc_q;
  logic       crc_fb;

  assign crc_fb = crc_q[7] ^ ccff_tail;

  // CRC-8 (poly 0x07) over the bits leaving the chain tail
  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset)
      crc_q <= 8'h00;
    else if (state_q == IDLE && start)
      crc_q <= 8'h00;
    else if (en_q)
      crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  end

  assign crc_out = crc_q;
`else
  logic tail_unused;

  assign tail_unused = ccff_tail;
  assign crc_out     = 8'h00;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 17-flop chain model.
// Optional CRC checks follow CCFF_CRC_EN.
module tb_ccff_chain_loader;

  localparam int CL = 17;
  localparam logic [16:0] P17 = 17'b1010_0101_0011_1100_1;

  logic        prog_clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  word_in = 8'h00;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        ccff_tail;
  logic        busy;
  logic        done;
  logic [7:0]  crc_out;

  logic [CL-1:0] chain_m = '0;

  int n_chk = 0;
  int n_fail = 0;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
    .prog_clk(prog_clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail(ccff_tail),
    .busy(busy),
    .done(done),
    .crc_out(crc_out)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain model
  always @(posedge prog_clk)
    if (ccff_shift_en) chain_m <= {chain_m[CL-2:0], ccff_head};

  assign ccff_tail = chain_m[CL-1];

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] word;
    logic [4:0] exp;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c,
                                          input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_exp(input logic [7:0] m);
`ifdef CCFF_CRC_EN
    return m;
`else
    return 8'h00 & m;
`endif
  endfunction

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int stall,
                          output logic [16:0] bits, output int nbits,
                          output int done_at, output int ndone,
                          output logic [7:0] crc_m);
    logic [7:0] wd [3];
    int idx;
    int st;
    bit fin;
    wd[0] = w0; wd[1] = w1; wd[2] = w2;
    idx = 0; st = stall; fin = 0;
    bits = '0; nbits = 0; done_at = -1; ndone = 0; crc_m = 8'h00;
    @(negedge prog_clk);
    start = 1'b1;
    word_valid = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge prog_clk);
      start = 1'b0;
      #1;
      if (ccff_shift_en) begin
        bits = {bits[15:0], ccff_head};
        nbits++;
        crc_m = crc_step(crc_m, ccff_tail);
      end
      if (done) begin
        ndone++;
        done_at = c;
      end
      if (!busy) begin
        fin = 1;
        break;
      end
      if (word_ready && idx < 3) begin
        if (idx == 1 && st > 0) begin
          st--;
          word_valid = 1'b0;
        end else begin
          word_valid = 1'b1;
          word_in = wd[idx];
          idx++;
        end
      end else begin
        word_valid = 1'b0;
      end
    end
    word_valid = 1'b0;
    if (!fin) chk("load_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0]  wa;
    logic [7:0]  wb;
    logic [16:0] bits;
    logic [7:0]  crc_m;
    logic [5:0]  hb;
    int nb, dat, nd, cnt;
    bit hit;

    wa = 8'hA5;
    wb = 8'h3C;
    vec[0]  = '{1'b1, 1'b0, 8'h00, 5'b00000};
    vec[1]  = '{1'b0, 1'b1, 8'hA5, 5'b10010};
    for (int b = 0; b < 8; b++)
      vec[2 + b] = '{1'b0, 1'b0, 8'h00, {1'b0, wa[7 - b], 3'b110}};
    vec[10] = '{1'b0, 1'b1, 8'h3C, 5'b10010};
    for (int b = 0; b < 8; b++)
      vec[11 + b] = '{1'b0, 1'b0, 8'h00, {1'b0, wb[7 - b], 3'b110}};
    vec[19] = '{1'b0, 1'b1, 8'h80, 5'b10010};
    vec[20] = '{1'b0, 1'b0, 8'h00, 5'b01110};
    vec[21] = '{1'b0, 1'b0, 8'h00, 5'b00011};
    vec[22] = '{1'b0, 1'b0, 8'h00, 5'b00000};

    // Reset state
    #2;
    chk("reset_outs",
        32'({word_ready, ccff_head, ccff_shift_en, busy, done, crc_out}),
        32'd0);
    @(negedge prog_clk);
    reset = 1'b1;

    // Test 1: cycle-by-cycle basic load
    for (int i = 0; i < 23; i++) begin
      @(negedge prog_clk);
      start = vec[i].start;
      word_valid = vec[i].valid;
      word_in = vec[i].word;
      #1;
      chk($sformatf("basic_row%0d", i),
          32'({word_ready, ccff_head, ccff_shift_en, busy, done, crc_out}),
          32'({vec[i].exp, 8'h00}));
    end
    chk("basic_chain", 32'(chain_m), 32'(P17));

    // Test 2: host stall before the second word
    run_load(8'hA5, 8'h3C, 8'h80, 5, bits, nb, dat, nd, crc_m);
    chk("stall_bits", 32'(bits), 32'(P17));
    chk("stall_nbits", 32'(nb), 32'd17);
    chk("stall_done_at", 32'(dat), 32'd26);
    chk("stall_ndone", 32'(nd), 32'd1);

    // Test 3: abort after 10 shifted bits
    @(negedge prog_clk);
    start = 1'b1;
    nb = 0; cnt = 0; hit = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge prog_clk);
      start = 1'b0;
      #1;
      if (ccff_shift_en) nb++;
      if (nb == 10) begin
        abort = 1'b1;
        word_valid = 1'b0;
        hit = 1;
        break;
      end
      if (word_ready) begin
        word_valid = 1'b1;
        word_in = (cnt == 0) ? 8'hA5 : 8'h3C;
        cnt++;
      end else begin
        word_valid = 1'b0;
      end
    end
    if (!hit) chk("abort_timeout", 32'd0, 32'd1);
    @(negedge prog_clk);
    abort = 1'b0;
    #1;
    chk("abort_en", 32'(ccff_shift_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge prog_clk);
      #1;
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    // Abort in FETCH blocks the offered word
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b1;
    word_valid = 1'b1;
    word_in = 8'hFF;
    #1;
    chk("abort_ready", 32'(word_ready), 32'd0);
    @(negedge prog_clk);
    abort = 1'b0;
    word_valid = 1'b0;
    #1;
    chk("abort_fetch_idle", 32'({busy, ccff_shift_en}), 32'd0);

    run_load(8'hA5, 8'h3C, 8'h80, 0, bits, nb, dat, nd, crc_m);
    chk("post_abort_bits", 32'(bits), 32'(P17));
    chk("post_abort_chain", 32'(chain_m), 32'(P17));
    chk("post_abort_done_at", 32'(dat), 32'd21);

    // Test 4: start ignored mid-load, async reset at bit 6
    @(negedge prog_clk);
    start = 1'b1;
    nb = 0; cnt = 0; hit = 0; hb = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge prog_clk);
      start = 1'b0;
      #1;
      if (ccff_shift_en) begin
        nb++;
        hb = {hb[4:0], ccff_head};
      end
      if (nb == 3) start = 1'b1;
      if (nb == 6) begin
        hit = 1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outs",
            32'({word_ready, ccff_head, ccff_shift_en, busy, done,
                 crc_out}), 32'd0);
        break;
      end
      if (word_ready && cnt == 0) begin
        word_valid = 1'b1;
        word_in = 8'hA5;
        cnt++;
      end else begin
        word_valid = 1'b0;
      end
    end
    if (!hit) chk("reset_timeout", 32'd0, 32'd1);
    chk("start_ignored_bits", 32'(hb), 32'b101001);
    @(negedge prog_clk);
    start = 1'b0;
    word_valid = 1'b0;
    reset = 1'b1;
    run_load(8'hA5, 8'h3C, 8'h80, 0, bits, nb, dat, nd, crc_m);
    chk("post_reset_bits", 32'(bits), 32'(P17));
    chk("post_reset_done", 32'({dat[7:0], nd[7:0]}), 32'({8'd21, 8'd1}));

    // Test 5/6: tail readback CRC
    run_load(8'h00, 8'h00, 8'h00, 0, bits, nb, dat, nd, crc_m);
    chk("crc_zero_load", 32'(crc_out), 32'(crc_exp(crc_m)));
    run_load(8'hA5, 8'h3C, 8'h80, 0, bits, nb, dat, nd, crc_m);
    chk("crc_after_pattern", 32'(crc_out), 32'h00);
    run_load(8'h00, 8'h00, 8'h00, 0, bits, nb, dat, nd, crc_m);
    chk("crc_readback_model", 32'(crc_out), 32'(crc_exp(crc_m)));
`ifdef CCFF_CRC_EN
    chk("crc_readback_const", 32'(crc_out), 32'hDA);
`else
    chk("crc_readback_const", 32'(crc_out), 32'h00);
`endif
    chk("zero_chain", 32'(chain_m), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
